cdc_hs_rx_bus: RTL

Destination-side receiver for a two-phase (toggle) request/acknowledge bus crossing. It sits directly downstream of the 1-bit synchronizer, which it instantiates internally for the request toggle. It detects each new request and captures the quasi-static source data bus. It presents that data on a valid/ready interface to destination logic and returns an acknowledge toggle to the source domain.

---
 rtl/cdc_pkg.sv | 11 +
 rtl/cdc_synczr_rst_1bit.sv | 31 +++
 rtl/cdc_hs_rx_bus.sv | 82 ++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle request/acknowledge bus crossing.
package cdc_pkg;

    localparam int CDC_SYNC_DEPTH = 3;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_WAIT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/cdc_synczr_rst_1bit.sv
// Resettable multi-flop synchronizer for a single asynchronous bit.
module cdc_synczr_rst_1bit
    import cdc_pkg::*;
#(
    parameter int DEPTH = CDC_SYNC_DEPTH
) (
    input  logic clk,
    input  logic async_rst_n,
    input  logic scan_enable,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_ff;

    // Scan muxing is inserted by DFT; the pin exists only to keep the netlist hookup stable.
    logic scan_unused;
    assign scan_unused = scan_enable;

    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[DEPTH-2:0], d};
        end
    end

    assign q = sync_ff[DEPTH-1];

endmodule

// File: rtl/cdc_hs_rx_bus.sv
// Destination side of a toggle-handshake bus crossing: captures the quasi-static
// source bus on each new request and offers it on a valid/ready port.
module cdc_hs_rx_bus
    import cdc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              scan_enable,
    input  logic              src_req_tgl,
    input  logic [DATA_W-1:0] src_data,
    output logic              dst_ack_tgl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  xfer_cnt
);

    rx_state_t state, state_next;
    logic      req_sync;
    logic      req_seen;
    logic      new_req;
    logic      slot_free;
    logic      capture;
    logic      pop;

    cdc_synczr_rst_1bit #(
        .DEPTH (CDC_SYNC_DEPTH)
    ) u_req_sync (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .scan_enable (scan_enable),
        .d           (src_req_tgl),
        .q           (req_sync)
    );

    assign new_req   = req_sync ^ req_seen;
    assign slot_free = !out_valid || out_ready;
    assign capture   = new_req && slot_free;
    assign pop       = out_valid && out_ready;

    // NOTE: the default assignment first keeps state_next fully specified, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            RX_IDLE: if (new_req && !slot_free) state_next = RX_WAIT;
            RX_WAIT: if (capture)               state_next = RX_IDLE;
            default:                            state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture wins over pop: a simultaneous pop and capture reloads the slot with no bubble.
    // NOTE: out_data is reset too, so a reset mid-transfer leaves no stale word visible.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            req_seen    <= 1'b0;
            dst_ack_tgl <= 1'b0;
            xfer_cnt    <= '0;
        end else if (capture) begin
            out_data    <= src_data;
            out_valid   <= 1'b1;
            req_seen    <= req_sync;
            dst_ack_tgl <= ~dst_ack_tgl;
            xfer_cnt    <= xfer_cnt + CNT_W'(1);
        end else if (pop) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
